// File: rtl/sys_mem_ctr_if.sv
// Request/response bundle between the cache controller (master) and sys_mem_ctr (slave).
// SysParErr exists only when SYS_MEM_PARITY_EN is defined.
`ifndef RW_READ
`define RW_READ 1'b0
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b1
`endif

interface sys_mem_ctr_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              SysStrobe;
  logic              SysRW;
  logic [ADDR_W-1:0] SysAddr;
  logic [DATA_W-1:0] SysDataIn;
  logic [DATA_W-1:0] SysDataOut;
  logic              SysReady;
  logic              SysBusy;
  logic              SysBusyErr;
`ifdef SYS_MEM_PARITY_EN
  logic              SysParErr;

  modport master (
    output SysStrobe, SysRW, SysAddr, SysDataIn,
    input  SysDataOut, SysReady, SysBusy, SysBusyErr, SysParErr
  );
  modport slave (
    input  SysStrobe, SysRW, SysAddr, SysDataIn,
    output SysDataOut, SysReady, SysBusy, SysBusyErr, SysParErr
  );
`else
  modport master (
    output SysStrobe, SysRW, SysAddr, SysDataIn,
    input  SysDataOut, SysReady, SysBusy, SysBusyErr
  );
  modport slave (
    input  SysStrobe, SysRW, SysAddr, SysDataIn,
    output SysDataOut, SysReady, SysBusy, SysBusyErr
  );
`endif
endinterface

// File: rtl/sys_mem_ctr.sv
// Fixed-latency system memory responder: IDLE -> BUSY -> DONE, one-cycle SysReady.
// Optional per-word even parity storage/check when SYS_MEM_PARITY_EN is defined.
`ifndef RW_READ
`define RW_READ 1'b0
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b1
`endif

module sys_mem_ctr #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic          clock,
  input logic          reset,
  sys_mem_ctr_if.slave bus
);

`ifdef SYS_MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int         MEM_W     = DATA_W + PAR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              ready;
  logic              busy;
  logic              busy_err;
  logic [DATA_W-1:0] data_out;
  logic              par_err;

  logic              rw_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  logic [MEM_W-1:0]  mem [2**ADDR_W];

  logic              accept;
  logic              go_done;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              mem_we;

  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // With zero wait states the request completes straight from the input pins.
  always_comb begin
    accept    = (state == IDLE) && bus.SysStrobe;
    go_done   = (state == BUSY) && (cnt == 4'd1);
    cur_write = (rw_p0 == `RW_WRITE);
    cur_addr  = addr_p0;
    cur_data  = data_p0;
    if (WAIT_CYCLES == 0) begin
      go_done   = accept;
      cur_write = (bus.SysRW == `RW_WRITE);
      cur_addr  = bus.SysAddr;
      cur_data  = bus.SysDataIn;
    end
    mem_we  = go_done && cur_write && !reset;
    rd_word = mem[cur_addr];
`ifdef SYS_MEM_PARITY_EN
    wr_word = {even_par(cur_data), cur_data};
`else
    wr_word = cur_data;
`endif
  end

  // Request capture (p0): data path only, no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      rw_p0   <= bus.SysRW;
      addr_p0 <= bus.SysAddr;
      data_p0 <= bus.SysDataIn;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[cur_addr] <= wr_word;
  end

  // Control FSM; a reset while BUSY drops the request before the write edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      busy_err <= 1'b0;
      data_out <= '0;
      par_err  <= 1'b0;
    end else begin
      ready    <= 1'b0;
      data_out <= '0;
      par_err  <= 1'b0;
      if (bus.SysStrobe && busy) busy_err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= WAIT_INIT;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY:    cnt <= cnt - 4'd1;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (go_done) begin
        state <= DONE;
        ready <= 1'b1;
        if (!cur_write) begin
          data_out <= rd_word[DATA_W-1:0];
`ifdef SYS_MEM_PARITY_EN
          par_err  <= ^rd_word;
`endif
        end
      end
    end
  end

  assign bus.SysReady   = ready;
  assign bus.SysBusy    = busy;
  assign bus.SysBusyErr = busy_err;
  assign bus.SysDataOut = data_out;
`ifdef SYS_MEM_PARITY_EN
  assign bus.SysParErr  = par_err;
`else
  logic unused_par;
  assign unused_par = par_err;
`endif

endmodule

// File: tb/tb_sys_mem_ctr.sv
// Directed bench for sys_mem_ctr: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances side by side.
module tb_sys_mem_ctr;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sys_mem_ctr_if #(.ADDR_W(10), .DATA_W(32)) b2 ();
  sys_mem_ctr_if #(.ADDR_W(10), .DATA_W(32)) b0 ();

  sys_mem_ctr #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .bus(b2.slave));
  sys_mem_ctr #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(b0.slave));

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request on the WAIT_CYCLES=2 instance; ends in the cycle after SysReady.
  task automatic txn(input string nm, input logic rw, input logic [9:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    int lat;
    b2.SysStrobe = 1'b1;
    b2.SysRW     = rw;
    b2.SysAddr   = a;
    b2.SysDataIn = d;
    tick();
    b2.SysStrobe = 1'b0;
    b2.SysDataIn = '0;
    chk({nm, "_busy"}, 32'(b2.SysBusy), 32'd1);
    lat = 1;
    while (!b2.SysReady && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, "_lat"}, lat, 32'd3);
    chk({nm, "_data"}, b2.SysDataOut, exp);
    tick();
    chk({nm, "_pulse"}, {30'd0, b2.SysReady, b2.SysBusy}, 32'd0);
    chk({nm, "_dout0"}, b2.SysDataOut, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 10'h004, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 10'h004, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 10'h3FF, 32'h11112222, 32'h0};
    vecs[3] = '{1'b1, 10'h000, 32'h33334444, 32'h0};
    vecs[4] = '{1'b0, 10'h3FF, 32'h0,        32'h11112222};
    vecs[5] = '{1'b0, 10'h000, 32'h0,        32'h33334444};
    vecs[6] = '{1'b1, 10'h004, 32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1'b0, 10'h004, 32'h0,        32'hA5A5A5A5};

    b2.SysStrobe = 1'b0; b2.SysRW = 1'b0; b2.SysAddr = '0; b2.SysDataIn = '0;
    b0.SysStrobe = 1'b0; b0.SysRW = 1'b0; b0.SysAddr = '0; b0.SysDataIn = '0;

    // Reset state
    tick();
    chk("rst_ready", 32'(b2.SysReady), 32'd0);
    chk("rst_busy", 32'(b2.SysBusy), 32'd0);
    chk("rst_err", 32'(b2.SysBusyErr), 32'd0);
    chk("rst_dout", b2.SysDataOut, 32'd0);
    tick();
    reset = 1'b0;

    // Table: write/read latency, data, top/bottom address, back-to-back RAW
    for (int i = 0; i < 8; i++)
      txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

    // Reset mid-BUSY of a write aborts it
    txn("pre10", 1'b1, 10'h010, 32'h01234567, 32'h0);
    b2.SysStrobe = 1'b1; b2.SysRW = 1'b1; b2.SysAddr = 10'h010; b2.SysDataIn = 32'hBADBAD00;
    tick();
    b2.SysStrobe = 1'b0;
    chk("abort_busy", 32'(b2.SysBusy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_out", {30'd0, b2.SysReady, b2.SysBusy}, 32'd0);
    chk("abort_dout", b2.SysDataOut, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    txn("abort_rd", 1'b0, 10'h010, 32'h0, 32'h01234567);

    // Strobe during BUSY and DONE ignored, sticky SysBusyErr
    b2.SysStrobe = 1'b1; b2.SysRW = 1'b0; b2.SysAddr = 10'h004;
    tick();
    b2.SysRW = 1'b1; b2.SysDataIn = 32'h66666666;
    tick();
    b2.SysStrobe = 1'b0;
    chk("berr_set", 32'(b2.SysBusyErr), 32'd1);
    tick();
    chk("berr_ready", 32'(b2.SysReady), 32'd1);
    chk("berr_data", b2.SysDataOut, 32'hA5A5A5A5);
    b2.SysStrobe = 1'b1; b2.SysRW = 1'b1; b2.SysDataIn = 32'h77777777;
    tick();
    b2.SysStrobe = 1'b0;
    chk("done_strobe_ign", {30'd0, b2.SysReady, b2.SysBusy}, 32'd0);
    txn("berr_rd", 1'b0, 10'h004, 32'h0, 32'hA5A5A5A5);
    chk("berr_sticky", 32'(b2.SysBusyErr), 32'd1);

    // WAIT_CYCLES=0: write then back-to-back read
    b0.SysStrobe = 1'b1; b0.SysRW = 1'b1; b0.SysAddr = 10'h001; b0.SysDataIn = 32'hCAFEF00D;
    tick();
    b0.SysStrobe = 1'b0;
    chk("w0_ready", {30'd0, b0.SysReady, b0.SysBusy}, 32'd3);
    chk("w0_dout", b0.SysDataOut, 32'd0);
    tick();
    chk("w0_idle", {30'd0, b0.SysReady, b0.SysBusy}, 32'd0);
    b0.SysStrobe = 1'b1; b0.SysRW = 1'b0; b0.SysAddr = 10'h001;
    tick();
    b0.SysStrobe = 1'b0;
    chk("r0_ready", 32'(b0.SysReady), 32'd1);
    chk("r0_data", b0.SysDataOut, 32'hCAFEF00D);
    tick();
    chk("r0_pulse", 32'(b0.SysReady), 32'd0);
    chk("r0_err", 32'(b0.SysBusyErr), 32'd0);

`ifdef SYS_MEM_PARITY_EN
    b2.SysStrobe = 1'b1; b2.SysRW = 1'b1; b2.SysAddr = 10'h020; b2.SysDataIn = 32'h0F0F0F0F;
    tick();
    b2.SysStrobe = 1'b0;
    tick(); tick(); tick();
    b2.SysStrobe = 1'b1; b2.SysRW = 1'b0;
    tick();
    b2.SysStrobe = 1'b0;
    tick(); tick();
    chk("par_clean", {30'd0, b2.SysReady, b2.SysParErr}, 32'd2);
    tick();
    dut.mem[32][0] = ~dut.mem[32][0];
    b2.SysStrobe = 1'b1;
    tick();
    b2.SysStrobe = 1'b0;
    tick(); tick();
    chk("par_bad", {30'd0, b2.SysReady, b2.SysParErr}, 32'd3);
    chk("par_data", b2.SysDataOut, 32'h0F0F0F0E);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
